// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the CPU front end.
//   NOP_INSTR      bubble encoding (RESET opcode; decode takes no action)
//   OP_*           major opcodes seen by fetch/decode
//   PCSEL_*        next-PC select encodings driven by decode
//   fetch_state_e  fetch controller states
package cpu_pkg;

  localparam logic [15:0] NOP_INSTR = 16'hF000;

  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;

  localparam logic [1:0] PCSEL_CALL = 2'b00;
  localparam logic [1:0] PCSEL_SEQ  = 2'b01;
  localparam logic [1:0] PCSEL_BR   = 2'b10;

  typedef enum logic [1:0] {
    FS_RUN      = 2'd0,
    FS_MISS     = 2'd1,
    FS_RET_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: combinational next-PC candidates for the fetch stage.
//   pc_i        current fetch PC
//   ifid_pc1_i  PC+1 of the instruction held in IFID (redirect base)
//   off_i       low 12 bits of the IFID instruction (offset field)
//   seq_pc_o    pc_i + 1
//   br_tgt_o    ifid_pc1_i + sext(off_i[8:0])   (conditional branch)
//   call_tgt_o  ifid_pc1_i + sext(off_i[11:0])  (CALL)
// All sums wrap modulo 2^PC_W.
module fetch_next_pc #(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] ifid_pc1_i,
  input  logic [11:0]     off_i,
  output logic [PC_W-1:0] seq_pc_o,
  output logic [PC_W-1:0] br_tgt_o,
  output logic [PC_W-1:0] call_tgt_o
);

  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] call_off;

  assign br_off     = {{(PC_W-9){off_i[8]}}, off_i[8:0]};
  assign call_off   = {{(PC_W-12){off_i[11]}}, off_i};

  assign seq_pc_o   = pc_i + PC_W'(1);
  assign br_tgt_o   = ifid_pc1_i + br_off;
  assign call_tgt_o = ifid_pc1_i + call_off;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage; owns the PC, reads the instruction
// cache and loads the IFID register, applying decode's stall/redirect/RET
// requests and absorbing cache misses by inserting bubbles.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ic_rd_en, ic_addr   cache read request / word address (= PC)
//   ic_instr, ic_rdy    cache data and same-cycle hit
//   stall_id            decode hazard stall (holds PC and IFID in RUN)
//   pc_sel, b_true      decode next-PC select and branch condition
//   ret_pend            decode holds a RET
//   ret_addr_vld/addr   popped return address (one-cycle pulse)
//   ifid_instr/pc1/bad  IFID register (bad=1 marks a bubble)
//   no_op_icache        fetch is waiting on a miss
//   perf_stall/miss/redir  saturating 16-bit event counters
//   fetch_state         controller state (debug visibility)
//
// Build option: define FETCH_PERF_CNT_EN to build the performance counters;
// otherwise they are absent and the outputs read 0.
//
// Handshake: the cache is a same-cycle responder; ic_instr is consumed at
// the clock edge of any cycle where ic_rd_en=1 and ic_rdy=1 and fetch is
// not stalled or redirected. Bubbles keep ifid_pc1 at its previous value.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W   = 16,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ic_rd_en,
  output logic [PC_W-1:0] ic_addr,
  input  logic [15:0]     ic_instr,
  input  logic            ic_rdy,
  input  logic            stall_id,
  input  logic [1:0]      pc_sel,
  input  logic            b_true,
  input  logic            ret_pend,
  input  logic            ret_addr_vld,
  input  logic [PC_W-1:0] ret_addr,
  output logic [15:0]     ifid_instr,
  output logic [PC_W-1:0] ifid_pc1,
  output logic            ifid_bad,
  output logic            no_op_icache,
  output logic [15:0]     perf_stall,
  output logic [15:0]     perf_miss,
  output logic [15:0]     perf_redir,
  output logic [1:0]      fetch_state
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [PC_W-1:0] pc1_q, pc1_d;
  logic            bad_q, bad_d;

  logic [PC_W-1:0] seq_pc, br_tgt, call_tgt;

  fetch_next_pc #(.PC_W(PC_W)) u_next_pc (
    .pc_i       (pc_q),
    .ifid_pc1_i (pc1_q),
    .off_i      (ir_q[11:0]),
    .seq_pc_o   (seq_pc),
    .br_tgt_o   (br_tgt),
    .call_tgt_o (call_tgt)
  );

  // State register (controller state plus PC/IFID datapath).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_RUN;
      pc_q    <= RST_PC;
      ir_q    <= NOP_INSTR;
      pc1_q   <= '0;
      bad_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pc1_q   <= pc1_d;
      bad_q   <= bad_d;
    end
  end

  // Next-state logic. In RUN the checks are ordered by priority.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    pc1_d   = pc1_q;
    bad_d   = bad_q;
    unique case (state_q)
      FS_RUN: begin
        if (stall_id) begin
          // hold everything
        end else if (ret_pend) begin
          ir_d    = NOP_INSTR;
          bad_d   = 1'b1;
          state_d = FS_RET_WAIT;
        end else if (pc_sel == PCSEL_CALL) begin
          pc_d  = call_tgt;
          ir_d  = NOP_INSTR;
          bad_d = 1'b1;
        end else if (pc_sel == PCSEL_BR && b_true) begin
          pc_d  = br_tgt;
          ir_d  = NOP_INSTR;
          bad_d = 1'b1;
        end else if (!ic_rdy) begin
          ir_d    = NOP_INSTR;
          bad_d   = 1'b1;
          state_d = FS_MISS;
        end else begin
          ir_d  = ic_instr;
          bad_d = 1'b0;
          pc1_d = seq_pc;
          pc_d  = seq_pc;
        end
      end
      FS_MISS: begin
        // IFID is already a bubble, so stall_id has nothing to hold here.
        if (ic_rdy) begin
          ir_d    = ic_instr;
          bad_d   = 1'b0;
          pc1_d   = seq_pc;
          pc_d    = seq_pc;
          state_d = FS_RUN;
        end else begin
          ir_d  = NOP_INSTR;
          bad_d = 1'b1;
        end
      end
      FS_RET_WAIT: begin
        ir_d  = NOP_INSTR;
        bad_d = 1'b1;
        if (ret_addr_vld) begin
          pc_d    = ret_addr;
          state_d = FS_RUN;
        end
      end
      default: state_d = FS_RUN;
    endcase
  end

  // Outputs.
  always_comb begin
    ic_rd_en     = (state_q != FS_RET_WAIT);
    no_op_icache = (state_q == FS_MISS);
    fetch_state  = state_q;
  end

  assign ic_addr    = pc_q;
  assign ifid_instr = ir_q;
  assign ifid_pc1   = pc1_q;
  assign ifid_bad   = bad_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_stall_q, perf_miss_q, perf_redir_q;
  logic        redir_ev;

  // A redirect is any RUN-state CALL, taken branch or RET entry that is
  // not masked by a stall.
  assign redir_ev = (state_q == FS_RUN) && !stall_id &&
                    (ret_pend || pc_sel == PCSEL_CALL ||
                     (pc_sel == PCSEL_BR && b_true));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_miss_q  <= '0;
      perf_redir_q <= '0;
    end else begin
      if (state_q == FS_RUN && stall_id && perf_stall_q != 16'hFFFF)
        perf_stall_q <= perf_stall_q + 16'd1;
      if (state_q == FS_MISS && perf_miss_q != 16'hFFFF)
        perf_miss_q <= perf_miss_q + 16'd1;
      if (redir_ev && perf_redir_q != 16'hFFFF)
        perf_redir_q <= perf_redir_q + 16'd1;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_miss  = perf_miss_q;
  assign perf_redir = perf_redir_q;
`else
  assign perf_stall = 16'h0000;
  assign perf_miss  = 16'h0000;
  assign perf_redir = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: bench for fetch_unit. A reference model of the fetch
// stage pushes the expected per-cycle outputs into exp_q; a monitor pops
// and compares them against the DUT each cycle. Directed sequences cover
// the main redirect/miss/RET scenarios, followed by random traffic.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int EW = 99;
  localparam int M_RUN = 0, M_MISS = 1, M_RETW = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic_rd_en;
  logic [15:0] ic_addr, ic_instr;
  logic        ic_rdy = 1'b1, stall_id = 1'b0, b_true = 1'b0;
  logic [1:0]  pc_sel = PCSEL_SEQ;
  logic        ret_pend = 1'b0, ret_addr_vld = 1'b0;
  logic [15:0] ret_addr = 16'h0000;
  logic [15:0] ifid_instr, ifid_pc1;
  logic        ifid_bad, no_op_icache;
  logic [15:0] perf_stall, perf_miss, perf_redir;
  logic [1:0]  fetch_state;

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  assign ic_instr = mem[ic_addr];

  fetch_unit dut (
    .clk(clk), .rst(rst), .ic_rd_en(ic_rd_en), .ic_addr(ic_addr),
    .ic_instr(ic_instr), .ic_rdy(ic_rdy), .stall_id(stall_id),
    .pc_sel(pc_sel), .b_true(b_true), .ret_pend(ret_pend),
    .ret_addr_vld(ret_addr_vld), .ret_addr(ret_addr),
    .ifid_instr(ifid_instr), .ifid_pc1(ifid_pc1), .ifid_bad(ifid_bad),
    .no_op_icache(no_op_icache), .perf_stall(perf_stall),
    .perf_miss(perf_miss), .perf_redir(perf_redir),
    .fetch_state(fetch_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  bit          m_known = 0;
  int          m_mode;
  logic [15:0] m_pc, m_ir, m_pc1;
  logic        m_bad;
  logic [15:0] m_ps, m_pm, m_pr;

  function automatic logic [15:0] sext(input logic [15:0] v, input int bits);
    int o;
    o = int'(v) & ((1 << bits) - 1);
    if (o >= (1 << (bits - 1))) o = o - (1 << bits);
    return 16'(o);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic m_bubble();
    m_ir  = NOP_INSTR;
    m_bad = 1'b1;
  endtask

  task automatic m_deliver();
    m_ir  = mem[m_pc];
    m_bad = 1'b0;
    m_pc1 = m_pc + 16'd1;
    m_pc  = m_pc + 16'd1;
  endtask

  task automatic model_step(input logic r, st, rp, input logic [1:0] sel,
                            input logic bt, rdy, vld, input logic [15:0] ra);
    if (r) begin
      m_known = 1; m_mode = M_RUN; m_pc = 16'h0000; m_ir = NOP_INSTR;
      m_pc1 = 16'h0000; m_bad = 1'b1; m_ps = 0; m_pm = 0; m_pr = 0;
    end else if (m_mode == M_RUN) begin
      if (st) m_ps = sat_inc(m_ps);
      else if (rp) begin m_bubble(); m_mode = M_RETW; m_pr = sat_inc(m_pr); end
      else if (sel == 2'b00) begin
        m_pc = m_pc1 + sext(m_ir, 12); m_bubble(); m_pr = sat_inc(m_pr);
      end else if (sel == 2'b10 && bt) begin
        m_pc = m_pc1 + sext(m_ir, 9); m_bubble(); m_pr = sat_inc(m_pr);
      end else if (!rdy) begin m_bubble(); m_mode = M_MISS; end
      else m_deliver();
    end else if (m_mode == M_MISS) begin
      m_pm = sat_inc(m_pm);
      if (rdy) begin m_deliver(); m_mode = M_RUN; end
      else m_bubble();
    end else begin
      m_bubble();
      if (vld) begin m_pc = ra; m_mode = M_RUN; end
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] model_outputs();
    logic [15:0] ps, pm, pr;
`ifdef FETCH_PERF_CNT_EN
    ps = m_ps; pm = m_pm; pr = m_pr;
`else
    ps = 16'h0; pm = 16'h0; pr = 16'h0;
`endif
    return {m_bad, m_ir, m_pc1, (m_mode != M_RETW), m_pc, (m_mode == M_MISS),
            ps, pm, pr};
  endfunction

  initial begin
    logic [EW-1:0] e, a;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {ifid_bad, ifid_instr, ifid_pc1, ic_rd_en, ic_addr, no_op_icache,
             perf_stall, perf_miss, perf_redir};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL stream t=%0t bad/instr/pc1 %b/%h/%h vs %b/%h/%h rd/addr/noop %b/%h/%b vs %b/%h/%b perf %h/%h/%h vs %h/%h/%h",
                   $time, a[98], a[97:82], a[81:66], e[98], e[97:82], e[81:66],
                   a[65], a[64:49], a[48], e[65], e[64:49], e[48],
                   a[47:32], a[31:16], a[15:0], e[47:32], e[31:16], e[15:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: drive inputs, record the expected outputs of this cycle,
  // advance the model, then return just after the clock edge.
  task automatic cycle(input logic r, st, rp, input logic [1:0] sel,
                       input logic bt, rdy, vld, input logic [15:0] ra);
    @(negedge clk);
    rst = r; stall_id = st; ret_pend = rp; pc_sel = sel; b_true = bt;
    ic_rdy = rdy; ret_addr_vld = vld; ret_addr = ra;
    if (m_known) exp_q.push_back(model_outputs());
    model_step(r, st, rp, sel, bt, rdy, vld, ra);
    @(posedge clk);
    #1;
  endtask

  task automatic seq(input logic rdy);
    cycle(0, 0, 0, PCSEL_SEQ, 0, rdy, 0, 16'h0);
  endtask

  initial begin
    logic        st, rp, bt, rdy, vld, r;
    logic [1:0]  sel;
    int          k;

    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0000] = 16'h1000; mem[16'h0001] = 16'h1001;
    mem[16'h0002] = 16'h1002; mem[16'h0003] = 16'h1003;
    mem[16'h0008] = 16'h1234;
    mem[16'h0010] = 16'hC1FE;  // branch, 9-bit offset -2
    mem[16'h0042] = 16'hD020;  // CALL +0x20
    mem[16'h0063] = 16'hDFA4;  // CALL -0x5C

    // reset
    cycle(1, 0, 0, PCSEL_SEQ, 0, 1, 0, 16'h0);
    cycle(1, 0, 0, PCSEL_SEQ, 0, 1, 0, 16'h0);
    chk("rst_addr", ic_addr, 16'h0000);
    chk("rst_bad", ifid_bad, 1);
    chk("rst_instr", ifid_instr, 16'hF000);
    chk("rst_pc1", ifid_pc1, 16'h0000);
    chk("rst_noop", no_op_icache, 0);

    // sequential fetch from 0..3
    for (int i = 0; i < 4; i++) begin
      seq(1);
      chk("seq_pc1", ifid_pc1, 32'(i + 1));
      chk("seq_bad", ifid_bad, 0);
    end
    for (int i = 4; i <= 16; i++) seq(1);
    chk("br_ifid", ifid_instr, 16'hC1FE);

    // stall holds a pending taken branch, then it is taken
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 0, PCSEL_BR, 1, 1, 0, 16'h0);
      chk("stall_addr", ic_addr, 16'h0011);
      chk("stall_instr", ifid_instr, 16'hC1FE);
    end
    cycle(0, 0, 0, PCSEL_BR, 1, 1, 0, 16'h0);
    chk("br_tgt", ic_addr, 16'h000F);
    chk("br_bubble", ifid_bad, 1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_redir", perf_redir, 1);
    chk("perf_stall", perf_stall, 2);
`else
    chk("perf_redir_off", perf_redir, 0);
`endif

    // RET: bubble on entry, two idle waits, address arrives, then fetch
    seq(1);
    chk("ret_pre_pc1", ifid_pc1, 16'h0010);
    cycle(0, 0, 1, PCSEL_SEQ, 0, 1, 0, 16'h0);
    chk("ret_bub0", ifid_bad, 1);
    chk("ret_rd0", ic_rd_en, 0);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 0, PCSEL_BR, 1, 1, 0, 16'h0);
      chk("ret_wait_bad", ifid_bad, 1);
      chk("ret_wait_rd", ic_rd_en, 0);
    end
    cycle(0, 0, 0, PCSEL_SEQ, 0, 1, 1, 16'h0042);
    chk("ret_bub3", ifid_bad, 1);
    chk("ret_addr", ic_addr, 16'h0042);
    seq(1);
    chk("ret_fetch_pc1", ifid_pc1, 16'h0043);
    chk("ret_fetch_instr", ifid_instr, 16'hD020);

    // CALL forward, then CALL backward to 0x0008
    cycle(0, 0, 0, PCSEL_CALL, 0, 1, 0, 16'h0);
    chk("call_tgt", ic_addr, 16'h0063);
    chk("call_bubble", ifid_bad, 1);
    seq(1);
    cycle(0, 0, 0, PCSEL_CALL, 0, 1, 0, 16'h0);
    chk("call_back_tgt", ic_addr, 16'h0008);

    // five-cycle miss at 0x0008
    for (int i = 0; i < 5; i++) begin
      seq(0);
      chk("miss_noop", no_op_icache, 1);
      chk("miss_bad", ifid_bad, 1);
    end
    seq(1);
    chk("miss_done_noop", no_op_icache, 0);
    chk("miss_done_pc1", ifid_pc1, 16'h0009);
    chk("miss_done_instr", ifid_instr, 16'h1234);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_miss", perf_miss, 5);
`endif

    // reset out of MISS, and out of RET_WAIT with a coincident return address
    seq(0);
    cycle(1, 0, 0, PCSEL_SEQ, 0, 0, 0, 16'h0);
    chk("rst_miss_addr", ic_addr, 16'h0000);
    chk("rst_miss_noop", no_op_icache, 0);
    seq(1);
    cycle(0, 0, 1, PCSEL_SEQ, 0, 1, 0, 16'h0);
    cycle(1, 0, 0, PCSEL_SEQ, 0, 1, 1, 16'h1234);
    chk("rst_ret_addr", ic_addr, 16'h0000);
    chk("rst_ret_rd", ic_rd_en, 1);
    seq(1);
    chk("rst_ret_pc1", ifid_pc1, 16'h0001);

    // stray return address in RUN is ignored
    cycle(0, 0, 0, PCSEL_SEQ, 0, 1, 1, 16'h5555);
    chk("stray_vld_addr", ic_addr, 16'h0002);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      st  = ($urandom_range(0, 7) == 0);
      rp  = 0;
      sel = PCSEL_SEQ;
      bt  = 1'($urandom_range(0, 1));
      if (m_mode == M_RUN && !m_bad) begin
        k = $urandom_range(0, 19);
        if (k == 0) rp = 1;
        else if (k < 3) sel = PCSEL_CALL;
        else if (k < 10) sel = PCSEL_BR;
      end else if (m_mode != M_RUN) begin
        // decode-side noise that must be ignored outside RUN
        k = $urandom_range(0, 3);
        if (k == 0) sel = PCSEL_CALL;
        else if (k == 1) sel = PCSEL_BR;
        rp = ($urandom_range(0, 3) == 0);
      end
      rdy = ($urandom_range(0, 4) != 0);
      vld = (m_mode == M_RETW) ? ($urandom_range(0, 2) == 0)
                               : ($urandom_range(0, 9) == 0);
      r   = ($urandom_range(0, 299) == 0);
      cycle(r, st, rp, sel, bt, rdy, vld, 16'($urandom));
    end

    seq(1);
    seq(1);
    @(negedge clk);
    #4;
    chk("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
